// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// Module  : fetch_stage_pkg
// Purpose : Shared constants and types for the pd5 fetch stage.
//           Holds the opcode constants, the NOP encoding, the reset PC and
//           the {pc, insn} buffer entry type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  // Base opcode constants
  localparam logic [6:0]  c_opc_op_imm = 7'b001_0011;
  localparam logic [6:0]  c_opc_op     = 7'b011_0011;
  localparam logic [6:0]  c_opc_branch = 7'b110_0011;
  localparam logic [6:0]  c_opc_jal    = 7'b110_1111;

  // addi x0, x0, 0
  localparam logic [31:0] c_nop        = {25'd0, c_opc_op_imm};

  localparam int          c_xlen       = 32;
  localparam logic [31:0] c_base_addr  = 32'h0100_0000;

  // One buffered fetch: the instruction and the address it came from.
  typedef struct packed {
    logic [c_xlen-1:0] pc;
    logic [c_xlen-1:0] insn;
  } fetch_entry_t;

endpackage : fetch_stage_pkg

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Purpose : DEPTH-entry FIFO of fetch entries (DEPTH a power of two, >= 2).
//           clear has priority over push/pop; a push in the clear cycle
//           lands as the single surviving entry.
// Ports   : clk, rst     - clock, synchronous active-high reset
//           clear        - drop all entries
//           push, push_data - enqueue at the tail
//           pop          - remove the head (caller guarantees non-empty)
//           count        - number of valid entries
//           head         - entry at the head (meaningless when count == 0)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output entry_t                   head
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = c_pw + 1;

  entry_t            r_mem [DEPTH];
  logic [c_pw-1:0]   r_rd;
  logic [c_pw-1:0]   r_wr;
  logic [c_cw-1:0]   r_count;
  logic [c_pw-1:0]   w_waddr;

  // A clear restarts both pointers at 0, so a push alongside it goes to slot 0.
  assign w_waddr = clear ? '0 : r_wr;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      r_mem[w_waddr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_rd    <= '0;
      r_wr    <= push ? c_pw'(1) : '0;
      r_count <= push ? c_cw'(1) : '0;
    end else begin
      if (push) begin
        r_wr <= r_wr + c_pw'(1);
      end
      if (pop) begin
        r_rd <= r_rd + c_pw'(1);
      end
      r_count <= r_count + c_cw'(push) - c_cw'(pop);
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd];

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !clear && (r_count == c_cw'(DEPTH))));

endmodule : fetch_fifo

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Purpose : Instruction fetch for the pd5 pipeline. Owns the PC, issues
//           requests to a 1-cycle-latency instruction memory, buffers the
//           responses in fetch_fifo and hands {pc, insn} to decode with a
//           valid/ready handshake. Redirects flush buffered and in-flight
//           fetches.
// Config  : FETCH_MISALIGN_CHECK_EN - when defined, a misaligned redirect
//           enqueues one NOP entry flagged by misalign_o and halts fetch
//           until the next redirect or reset. When undefined, redirect
//           targets are forced word aligned and misalign_o is 0.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           imem_req_o, imem_addr_o  - fetch request / word address
//           imem_rdata_i             - instruction, one cycle after request
//           redirect_i, redirect_pc_i- control-flow change from execute
//           valid_o, ready_i         - handshake to decode
//           pc_o, insn_o             - head entry (0 / NOP when not valid)
//           misalign_o               - head is a misaligned-redirect marker
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                DWIDTH    = 32,
  parameter int                AWIDTH    = 32,
  parameter int                DEPTH     = 2,
  parameter logic [AWIDTH-1:0] BASE_ADDR = c_base_addr
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic              misalign_o
);

  localparam int c_cw = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-1:0] r_inflight_pc;
  logic              r_inflight;

  logic [c_cw-1:0]   w_count;
  logic [c_cw:0]     w_occ;
  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_push;
  logic              w_halt;
  logic              w_misalign_redirect;
  logic [AWIDTH-1:0] w_redirect_pc;
  entry_t            w_push_data;
  entry_t            w_head;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_halt;

  assign w_misalign_redirect = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign w_redirect_pc       = redirect_pc_i;
  assign w_halt              = r_halt;
  // While halted the only possible FIFO content is the marker entry.
  assign misalign_o          = r_halt && w_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt <= 1'b0;
    end else if (redirect_i) begin
      r_halt <= w_misalign_redirect;
    end
  end
`else
  assign w_misalign_redirect = 1'b0;
  assign w_redirect_pc       = redirect_pc_i & ~AWIDTH'(3);
  assign w_halt              = 1'b0;
  assign misalign_o          = 1'b0;
`endif

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && ready_i && !redirect_i;

  // Slots already committed: buffered entries plus the response on its way.
  assign w_occ   = {1'b0, w_count} + {{c_cw{1'b0}}, r_inflight};
  assign w_issue = !rst && !redirect_i && !w_halt &&
                   ((w_occ < (c_cw + 1)'(DEPTH)) || w_pop);

  // On a redirect the in-flight response is dropped; only the misalign
  // marker may be enqueued in that cycle.
  assign w_push  = redirect_i ? w_misalign_redirect : r_inflight;
  always_comb begin
    w_push_data = '{pc: r_inflight_pc, insn: imem_rdata_i};
    if (redirect_i) begin
      w_push_data = '{pc: redirect_pc_i, insn: DWIDTH'(c_nop)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= BASE_ADDR;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_i) begin
      r_pc          <= w_redirect_pc;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + AWIDTH'(4);
        r_inflight_pc <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_i),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .count     (w_count),
    .head      (w_head)
  );

  assign imem_req_o  = w_issue;
  assign imem_addr_o = r_pc;
  assign valid_o     = w_valid;
  assign pc_o        = w_valid ? w_head.pc   : '0;
  assign insn_o      = w_valid ? w_head.insn : DWIDTH'(c_nop);

endmodule : fetch_stage

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Purpose : Self-checking bench for fetch_stage. A queue-based reference
//           model is compared against the DUT every cycle, alongside a
//           directed sequence with literal expectations and a randomized
//           phase (stalls, redirects, resets).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic        misalign_o;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .pc_o          (pc_o),
    .insn_o        (insn_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // Instruction memory: answers a request one cycle later, noise otherwise.
  always @(posedge clk) begin
    imem_rdata_i <= imem_req_o ? mem_f(imem_addr_o) : $urandom;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: a queue of {pc, insn, misalign} plus one in-flight
  // slot, advanced once per cycle from the inputs seen at the edge.
  // ------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    bit          mis;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  bit          m_infl = 1'b0;
  bit          m_halt = 1'b0;
  bit          m_live = 1'b0;

  always @(negedge clk) begin
    bit          e_valid;
    bit          e_pop;
    bit          e_req;
    logic [31:0] e_pc;
    logic [31:0] e_insn;
    bit          e_mis;
    e_valid = (mq.size() != 0);
    e_pop   = e_valid && ready_i;
    e_req   = !rst && !redirect_i && !m_halt &&
              (((mq.size() + int'(m_infl)) < DEPTH) || e_pop);
    e_pc    = e_valid ? mq[0].pc   : 32'h0;
    e_insn  = e_valid ? mq[0].insn : NOP;
    e_mis   = e_valid && mq[0].mis;
    if (m_live) begin
      check("m_req",      {31'd0, imem_req_o}, {31'd0, e_req});
      check("m_addr",     imem_addr_o,         m_pc);
      check("m_valid",    {31'd0, valid_o},    {31'd0, e_valid});
      check("m_pc",       pc_o,                e_pc);
      check("m_insn",     insn_o,              e_insn);
      check("m_misalign", {31'd0, misalign_o}, {31'd0, e_mis});
    end
    if (rst) begin
      mq.delete();
      m_pc   = BASE;
      m_infl = 1'b0;
      m_halt = 1'b0;
      m_live = 1'b1;
    end else if (redirect_i) begin
      mq.delete();
      m_infl = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      m_pc   = redirect_pc_i;
      m_halt = (redirect_pc_i % 4) != 0;
      if (m_halt) mq.push_back('{redirect_pc_i, NOP, 1'b1});
`else
      m_pc   = redirect_pc_i - (redirect_pc_i % 4);
`endif
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_infl) mq.push_back('{m_ipc, mem_f(m_ipc), 1'b0});
      m_infl = e_req;
      if (e_req) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------
  // Stimulus with literal expectations
  // ------------------------------------------------------------------
  initial begin
    rst = 1'b1; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    tick();
    @(negedge clk);
    check("rst_valid",    {31'd0, valid_o},    32'd0);
    check("rst_insn",     insn_o,              NOP);
    check("rst_pc",       pc_o,                32'h0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    check("rst_req",      {31'd0, imem_req_o}, 32'd0);

    // cycle 0..2: first fetch reaches decode two cycles after its request
    tick(); rst = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    check("c0_req",  {31'd0, imem_req_o}, 32'd1);
    check("c0_addr", imem_addr_o,         32'h0100_0000);
    tick(); @(negedge clk);
    check("c1_valid", {31'd0, valid_o}, 32'd0);
    tick(); @(negedge clk);
    check("c2_valid", {31'd0, valid_o}, 32'd1);
    check("c2_pc",    pc_o,             32'h0100_0000);
    check("c2_insn",  insn_o,           mem_f(32'h0100_0000));

    // stall cycles 3..12
    tick(); ready_i = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    check("stall_req",   {31'd0, imem_req_o}, 32'd0);
    check("stall_valid", {31'd0, valid_o},    32'd1);
    check("stall_pc",    pc_o,                32'h0100_0004);
    tick(); ready_i = 1'b1; @(negedge clk);
    check("rel_pc0", pc_o, 32'h0100_0004);
    tick(); @(negedge clk);
    check("rel_pc1", pc_o, 32'h0100_0008);
    tick(); @(negedge clk);
    check("rel_pc2", pc_o, 32'h0100_000C);

    // redirect with a full buffer
    tick(); ready_i = 1'b0;
    tick();
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h0100_0100;
    @(negedge clk);
    check("redir_req", {31'd0, imem_req_o}, 32'd0);
    tick(); redirect_i = 1'b0; redirect_pc_i = $urandom; ready_i = 1'b1;
    @(negedge clk);
    check("redir_req1",  {31'd0, imem_req_o}, 32'd1);
    check("redir_addr1", imem_addr_o,         32'h0100_0100);
    check("redir_flush", {31'd0, valid_o},    32'd0);
    tick(); @(negedge clk);
    check("redir_v2", {31'd0, valid_o}, 32'd0);
    tick(); @(negedge clk);
    check("redir_v3",  {31'd0, valid_o}, 32'd1);
    check("redir_pc3", pc_o,             32'h0100_0100);

    // back-to-back redirects: the second wins
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    tick(); redirect_pc_i = 32'h0000_0300;
    @(negedge clk);
    check("b2b_valid", {31'd0, valid_o}, 32'd0);
    tick(); redirect_i = 1'b0; @(negedge clk);
    check("b2b_addr", imem_addr_o, 32'h0000_0300);
    tick(); tick(); @(negedge clk);
    check("b2b_pc0", pc_o, 32'h0000_0300);
    tick(); @(negedge clk);
    check("b2b_pc1", pc_o, 32'h0000_0304);

    // reset mid-stream
    tick(); rst = 1'b1; @(negedge clk);
    check("mrst_valid_before", {31'd0, valid_o}, 32'd1);
    tick(); rst = 1'b0; @(negedge clk);
    check("mrst_valid", {31'd0, valid_o}, 32'd0);
    check("mrst_insn",  insn_o,           NOP);
    check("mrst_addr",  imem_addr_o,      BASE);
    tick(); tick(); @(negedge clk);
    check("mrst_pc", pc_o, BASE);

    // misaligned redirect
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h0100_0102;
    tick(); redirect_i = 1'b0; @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_valid", {31'd0, valid_o},    32'd1);
    check("mis_flag",  {31'd0, misalign_o}, 32'd1);
    check("mis_pc",    pc_o,                32'h0100_0102);
    check("mis_insn",  insn_o,              NOP);
    check("mis_req",   {31'd0, imem_req_o}, 32'd0);
    tick(); @(negedge clk);
    check("mis_req2",   {31'd0, imem_req_o}, 32'd0);
    check("mis_valid2", {31'd0, valid_o},    32'd0);
`else
    check("mis_flag", {31'd0, misalign_o}, 32'd0);
    check("mis_req",  {31'd0, imem_req_o}, 32'd1);
    check("mis_addr", imem_addr_o,         32'h0100_0100);
    tick(); tick(); @(negedge clk);
    check("mis_pc", pc_o, 32'h0100_0100);
`endif
    tick(); redirect_i = 1'b1; redirect_pc_i = BASE;
    tick(); redirect_i = 1'b0;

    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      int sel;
      tick();
      ready_i    = ($urandom_range(0, 9) < 7);
      rst        = ($urandom_range(0, 199) == 0);
      redirect_i = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       redirect_pc_i = BASE + ($urandom_range(0, 63) << 2);
        1:       redirect_pc_i = 32'hFFFF_FFF8;
        default: redirect_pc_i = $urandom & ~32'd3;
      endcase
      if ($urandom_range(0, 3) == 0) redirect_pc_i[1:0] = 2'($urandom_range(1, 3));
    end
    tick(); rst = 1'b0; redirect_i = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_stage

`default_nettype wire
